// File: rtl/glb_bank_arbiter.sv
// Round-robin arbiter that time-shares one GLB SRAM bank between NUM_REQ requesters (one grant per cycle).
// Latency: grant and SRAM controls are combinational, read response RD_LATENCY cycles later; backpressure: a requester holds until its req_gnt bit is high.
module glb_bank_arbiter #(
   parameter int NUM_REQ               = 3,
   parameter int RD_LATENCY            = 2,
   parameter int BANK_DATA_WIDTH       = 64,
   parameter int GLB_ADDR_WIDTH        = 20,
   parameter int BANK_ADDR_WIDTH       = 17,
   parameter int BANK_ADDR_BYTE_OFFSET = 3
) (
   input  logic                                             clk,
   input  logic                                             reset,
   input  logic [NUM_REQ-1:0]                               req_wr_en,
   input  logic [NUM_REQ-1:0][BANK_DATA_WIDTH/8-1:0]        req_wr_strb,
   input  logic [NUM_REQ-1:0][GLB_ADDR_WIDTH-1:0]           req_wr_addr,
   input  logic [NUM_REQ-1:0][BANK_DATA_WIDTH-1:0]          req_wr_data,
   input  logic [NUM_REQ-1:0]                               req_rd_en,
   input  logic [NUM_REQ-1:0][GLB_ADDR_WIDTH-1:0]           req_rd_addr,
   output logic [NUM_REQ-1:0]                               req_gnt,
   output logic [BANK_DATA_WIDTH-1:0]                       rdrs_data,
   output logic [NUM_REQ-1:0]                               rdrs_valid,
   output logic                                             mem_cen,
   output logic                                             mem_wen,
   output logic [BANK_ADDR_WIDTH-BANK_ADDR_BYTE_OFFSET-1:0] mem_addr,
   output logic [BANK_DATA_WIDTH-1:0]                       mem_data_in,
   output logic [BANK_DATA_WIDTH-1:0]                       mem_bit_en,
   input  logic [BANK_DATA_WIDTH-1:0]                       mem_data_out
);

   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int STRB_W = BANK_DATA_WIDTH / 8;
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

   typedef struct packed {
      logic             vld;
      logic [IDX_W-1:0] id;
   } rd_tag_t;

   logic [IDX_W-1:0]     last_gnt;
   logic                 gnt_any;
   logic [IDX_W-1:0]     gnt_idx;
   logic                 gnt_wr;
   logic [STRB_W-1:0]    gnt_strb;
   rd_tag_t              rd_pipe [RD_LATENCY];
   rd_tag_t              rd_exit;
   logic [BANK_DATA_WIDTH-1:0] rdrs_data_q;
   logic                 addr_unused;

   // Only the bank-local word address is used; tile/bank select and byte offset are dropped.
   assign addr_unused = ^{req_wr_addr, req_rd_addr};

   // Search starts one past the previous winner so every requester gets a turn.
   always_comb begin
      int               cand;
      logic [IDX_W-1:0] cand_idx;
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      cand     = 0;
      cand_idx = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = int'(last_gnt) + off;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = IDX_W'(cand);
         if (!gnt_any && (req_wr_en[cand_idx] || req_rd_en[cand_idx])) begin
            gnt_any = 1'b1;
            gnt_idx = cand_idx;
         end
      end
      if (reset) begin
         gnt_any = 1'b0;
      end
   end

   assign gnt_wr   = req_wr_en[gnt_idx];
   assign gnt_strb = req_wr_strb[gnt_idx];

   always_comb begin
      req_gnt     = '0;
      mem_cen     = 1'b0;
      mem_wen     = 1'b0;
      mem_addr    = '0;
      mem_data_in = '0;
      mem_bit_en  = '0;
      if (gnt_any) begin
         req_gnt[gnt_idx] = 1'b1;
         if (gnt_wr) begin
            // An all-zero strobe still consumes the request but skips the SRAM access.
            mem_cen     = |gnt_strb;
            mem_wen     = |gnt_strb;
            mem_addr    = req_wr_addr[gnt_idx][BANK_ADDR_WIDTH-1:BANK_ADDR_BYTE_OFFSET];
            mem_data_in = req_wr_data[gnt_idx];
            for (int b = 0; b < STRB_W; b++) begin
               mem_bit_en[b*8 +: 8] = {8{gnt_strb[b]}};
            end
         end else begin
            mem_cen    = 1'b1;
            mem_addr   = req_rd_addr[gnt_idx][BANK_ADDR_WIDTH-1:BANK_ADDR_BYTE_OFFSET];
            mem_bit_en = '1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_gnt    <= LAST_RST;
         rdrs_data_q <= '0;
         for (int i = 0; i < RD_LATENCY; i++) begin
            rd_pipe[i] <= '0;
         end
      end else begin
         if (gnt_any) begin
            last_gnt <= gnt_idx;
         end
         rd_pipe[0].vld <= gnt_any && !gnt_wr;
         rd_pipe[0].id  <= gnt_idx;
         for (int i = 1; i < RD_LATENCY; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
         end
         if (rd_exit.vld) begin
            rdrs_data_q <= mem_data_out;
         end
      end
   end

   // The tag leaves the pipe in the same cycle the SRAM presents the data.
   assign rd_exit = rd_pipe[RD_LATENCY-1];

   always_comb begin
      rdrs_valid = '0;
      rdrs_data  = rdrs_data_q;
      if (reset) begin
         rdrs_data = '0;
      end else if (rd_exit.vld) begin
         rdrs_valid[rd_exit.id] = 1'b1;
         rdrs_data              = mem_data_out;
      end
   end

endmodule

// File: tb/tb_glb_bank_arbiter.sv
// Directed bench for glb_bank_arbiter: a cycle-level reference model plus literal spot checks.
module tb_glb_bank_arbiter;

   localparam int NR  = 3;
   localparam int RDL = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [2:0]        req_wr_en;
   logic [2:0][7:0]   req_wr_strb;
   logic [2:0][19:0]  req_wr_addr;
   logic [2:0][63:0]  req_wr_data;
   logic [2:0]        req_rd_en;
   logic [2:0][19:0]  req_rd_addr;
   logic [2:0]        req_gnt;
   logic [63:0]       rdrs_data;
   logic [2:0]        rdrs_valid;
   logic              mem_cen;
   logic              mem_wen;
   logic [13:0]       mem_addr;
   logic [63:0]       mem_data_in;
   logic [63:0]       mem_bit_en;
   logic [63:0]       mem_data_out;

   glb_bank_arbiter #(.NUM_REQ(NR), .RD_LATENCY(RDL)) dut (
      .clk(clk), .reset(reset),
      .req_wr_en(req_wr_en), .req_wr_strb(req_wr_strb), .req_wr_addr(req_wr_addr),
      .req_wr_data(req_wr_data), .req_rd_en(req_rd_en), .req_rd_addr(req_rd_addr),
      .req_gnt(req_gnt), .rdrs_data(rdrs_data), .rdrs_valid(rdrs_valid),
      .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_data_in(mem_data_in), .mem_bit_en(mem_bit_en), .mem_data_out(mem_data_out)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: grant = first active requester after the previous winner;
   // each read is scheduled to answer exactly RDL cycles later.
   int          cyc = 0;
   int          m_last = NR - 1;
   int          m_gnt = -1;
   logic        m_gnt_wr = 1'b0;
   int          m_due [8];
   logic [63:0] m_rdata = '0;
   int          g;
   logic [1:0]  gi;
   logic        is_wr;
   logic [7:0]  e_strb;
   logic [2:0]  e_gnt, e_rv;
   logic        e_cen, e_wen;
   logic [63:0] e_addr, e_din, e_be;

   initial begin
      for (int k = 0; k < 8; k++) m_due[k] = -1;
   end

   always @(negedge clk) begin
      if (reset) begin
         chk("rst_gnt", 64'(req_gnt), 64'd0);
         chk("rst_cen", 64'(mem_cen), 64'd0);
         chk("rst_wen", 64'(mem_wen), 64'd0);
         chk("rst_addr", 64'(mem_addr), 64'd0);
         chk("rst_din", mem_data_in, 64'd0);
         chk("rst_be", mem_bit_en, 64'd0);
         chk("rst_rv", 64'(rdrs_valid), 64'd0);
         chk("rst_rdata", rdrs_data, 64'd0);
         m_last  = NR - 1;
         m_gnt   = -1;
         m_rdata = '0;
         for (int k = 0; k < 8; k++) m_due[k] = -1;
      end else begin
         g = -1;
         for (int off = 1; off <= NR; off++) begin
            int c;
            c = (m_last + off) % NR;
            if (g < 0 && ((((req_wr_en | req_rd_en) >> c) & 3'b001) != 3'b000)) g = c;
         end
         e_gnt = '0; e_cen = 0; e_wen = 0; e_addr = 0; e_din = 0; e_be = 0; is_wr = 0;
         if (g >= 0) begin
            gi    = 2'(g);
            e_gnt = 3'b001 << g;
            is_wr = req_wr_en[gi];
            if (is_wr) begin
               e_strb = req_wr_strb[gi];
               e_cen  = (e_strb != 8'h00);
               e_wen  = e_cen;
               e_addr = (64'(req_wr_addr[gi]) >> 3) & 64'h3FFF;
               e_din  = req_wr_data[gi];
               for (int b = 0; b < 8; b++)
                  if (((e_strb >> b) & 8'h01) != 8'h00) e_be = e_be | (64'hFF << (8 * b));
            end else begin
               e_cen  = 1;
               e_addr = (64'(req_rd_addr[gi]) >> 3) & 64'h3FFF;
               e_be   = {64{1'b1}};
            end
         end
         e_rv = '0;
         if (m_due[cyc % 8] >= 0) begin
            e_rv    = 3'b001 << m_due[cyc % 8];
            m_rdata = mem_data_out;
         end
         chk("gnt", 64'(req_gnt), 64'(e_gnt));
         chk("cen", 64'(mem_cen), 64'(e_cen));
         chk("wen", 64'(mem_wen), 64'(e_wen));
         chk("addr", 64'(mem_addr), e_addr);
         chk("din", mem_data_in, e_din);
         chk("bit_en", mem_bit_en, e_be);
         chk("rdrs_valid", 64'(rdrs_valid), 64'(e_rv));
         chk("rdrs_data", rdrs_data, m_rdata);
         m_due[cyc % 8] = -1;
         if (g >= 0 && !is_wr) m_due[(cyc + RDL) % 8] = g;
         if (g >= 0) m_last = g;
         m_gnt    = g;
         m_gnt_wr = is_wr;
      end
      cyc++;
   end

   // Driver: requests stay asserted until the model says they were granted.
   logic        hold_all = 1'b0;
   int          dcnt = 0;

   task automatic tick();
      @(posedge clk);
      #1;
      dcnt++;
      mem_data_out = {32'hD000_0000 + 32'(dcnt), 32'h5A5A_0000 + 32'(dcnt)};
      if (!hold_all && m_gnt >= 0) begin
         if (m_gnt_wr) req_wr_en = req_wr_en & ~(3'b001 << m_gnt);
         else          req_rd_en = req_rd_en & ~(3'b001 << m_gnt);
      end
   endtask

   function automatic int oh2idx(input logic [2:0] oh);
      case (oh)
         3'b001:  return 0;
         3'b010:  return 1;
         3'b100:  return 2;
         default: return -1;
      endcase
   endfunction

   logic [63:0] saved;
   int          pulses;
   int          cnt [3];
   int          exp_seq [6] = '{0, 1, 2, 0, 1, 2};

   initial begin
      reset = 1; req_wr_en = 0; req_rd_en = 0; mem_data_out = 0;
      req_wr_strb = '0; req_wr_addr = '0; req_wr_data = '0; req_rd_addr = '0;
      tick(); tick();
      req_wr_en = 3'b111; req_wr_strb = {3{8'hFF}};
      #1;
      chk("lit_rst_gnt", 64'(req_gnt), 64'd0);
      chk("lit_rst_cen", 64'(mem_cen), 64'd0);
      tick();
      req_wr_en = 0; req_wr_strb = '0; reset = 0;

      // single write
      req_wr_en[1] = 1; req_wr_strb[1] = 8'h0F; req_wr_addr[1] = 20'h00010; req_wr_data[1] = 64'hAABB;
      #1;
      chk("lit_wr_gnt", 64'(req_gnt), 64'h2);
      chk("lit_wr_wen", 64'(mem_wen), 64'h1);
      chk("lit_wr_addr", 64'(mem_addr), 64'h2);
      chk("lit_wr_be", mem_bit_en, 64'h0000_0000_FFFF_FFFF);
      chk("lit_wr_din", mem_data_in, 64'hAABB);
      tick();

      // read latency
      req_rd_en[0] = 1; req_rd_addr[0] = 20'h18;
      #1;
      chk("lit_rd_gnt", 64'(req_gnt), 64'h1);
      chk("lit_rd_addr", 64'(mem_addr), 64'h3);
      chk("lit_rd_wen", 64'(mem_wen), 64'h0);
      tick(); #1;
      chk("lit_rd_t1", 64'(rdrs_valid), 64'h0);
      tick(); #1;
      chk("lit_rd_t2", 64'(rdrs_valid), 64'h1);
      chk("lit_rd_data", rdrs_data, mem_data_out);
      saved = mem_data_out;
      tick(); #1;
      chk("lit_rd_t3", 64'(rdrs_valid), 64'h0);
      chk("lit_rd_hold", rdrs_data, saved);

      // zero-strobe write is consumed without an SRAM access
      req_wr_en[1] = 1; req_wr_strb[1] = 8'h00;
      #1;
      chk("lit_zs_gnt", 64'(req_gnt), 64'h2);
      chk("lit_zs_cen", 64'(mem_cen), 64'h0);
      tick(); #1;
      chk("lit_zs_done", 64'(req_gnt), 64'h0);
      tick();

      // fairness from reset
      reset = 1; tick(); reset = 0;
      hold_all = 1; req_wr_en = 3'b111; req_wr_strb = {3{8'hFF}};
      cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
      for (int i = 0; i < 30; i++) begin
         int w;
         #1;
         w = oh2idx(req_gnt);
         if (i < 6) chk("lit_fair_seq", 64'(w), 64'(exp_seq[i]));
         if (w >= 0) cnt[w]++;
         tick();
      end
      chk("lit_fair_r0", 64'(cnt[0]), 64'd10);
      chk("lit_fair_r1", 64'(cnt[1]), 64'd10);
      chk("lit_fair_r2", 64'(cnt[2]), 64'd10);
      req_wr_en = 0; hold_all = 0;

      // write wins over read from the same requester
      req_wr_en[2] = 1; req_rd_en[2] = 1; req_wr_addr[2] = 20'h40; req_rd_addr[2] = 20'h48;
      #1;
      chk("lit_wp_gnt0", 64'(req_gnt), 64'h4);
      chk("lit_wp_wen0", 64'(mem_wen), 64'h1);
      tick(); #1;
      chk("lit_wp_gnt1", 64'(req_gnt), 64'h4);
      chk("lit_wp_wen1", 64'(mem_wen), 64'h0);
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         tick(); #1;
         if (rdrs_valid[2]) pulses++;
      end
      chk("lit_wp_pulses", 64'(pulses), 64'd1);

      // pipelined reads
      req_rd_en = 3'b111; req_rd_addr[0] = 20'h20; req_rd_addr[1] = 20'h28; req_rd_addr[2] = 20'h30;
      #1;
      chk("lit_pl_g0", 64'(req_gnt), 64'h1);
      tick(); #1;
      chk("lit_pl_g1", 64'(req_gnt), 64'h2);
      tick(); #1;
      chk("lit_pl_g2", 64'(req_gnt), 64'h4);
      chk("lit_pl_v0", 64'(rdrs_valid), 64'h1);
      tick(); #1;
      chk("lit_pl_v1", 64'(rdrs_valid), 64'h2);
      tick(); #1;
      chk("lit_pl_v2", 64'(rdrs_valid), 64'h4);
      tick(); #1;
      chk("lit_pl_v3", 64'(rdrs_valid), 64'h0);

      // reset one cycle after a read grant
      req_rd_en[0] = 1;
      #1;
      chk("lit_mf_gnt", 64'(req_gnt), 64'h1);
      tick();
      reset = 1;
      tick();
      reset = 0;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (rdrs_valid != 3'b000) pulses++;
         tick();
      end
      chk("lit_mf_pulses", 64'(pulses), 64'd0);
      req_wr_en = 3'b111;
      #1;
      chk("lit_mf_tie", 64'(req_gnt), 64'h1);
      tick();
      req_wr_en = 0;
      tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
